// File: rtl/updown_counter_pkg.sv
// Shared types and defaults for the parametrised up/down counter.
package updown_counter_pkg;

  typedef enum logic {
    MODE_WRAP = 1'b0,
    MODE_SAT  = 1'b1
  } count_mode_e;

  localparam int DEF_WIDTH = 8;

endpackage

// File: rtl/updown_next_calc.sv
// Combinational next-count computation: bounded up/down step with wrap or clamp,
// plus the raw overflow/underflow conditions for the pulse registers.
module updown_next_calc
  import updown_counter_pkg::*;
#(
  parameter int          WIDTH = DEF_WIDTH,
  parameter count_mode_e MODE  = MODE_WRAP
) (
  input  logic [WIDTH-1:0] out,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] max_val,
  input  logic             up_down,
  output logic [WIDTH-1:0] nxt,
  output logic             wrap_up,
  output logic             wrap_dn
);

  // One extra bit keeps the carry of out+s and the full modulus max_val+1.
  logic [WIDTH:0] sum_s;
  logic [WIDTH:0] mod_s;
  logic [WIDTH:0] up_wrap_s;
  logic [WIDTH:0] dn_wrap_s;

  assign sum_s     = {1'b0, out} + {1'b0, s};
  assign mod_s     = {1'b0, max_val} + {{WIDTH{1'b0}}, 1'b1};
  assign up_wrap_s = sum_s - mod_s;
  assign dn_wrap_s = {1'b0, out} + mod_s - {1'b0, s};

  // Next count selection by direction, bound check and mode
  always_comb begin
    nxt     = out;
    wrap_up = 1'b0;
    wrap_dn = 1'b0;
    if (up_down) begin
      if (out > max_val) begin
        nxt     = (MODE == MODE_SAT) ? max_val : {WIDTH{1'b0}};
        wrap_up = 1'b1;
      end else if (max_val == {WIDTH{1'b0}}) begin
        // A modulus of one wraps on every up-count even though the step is zero.
        nxt     = {WIDTH{1'b0}};
        wrap_up = (MODE == MODE_WRAP);
      end else if (sum_s > {1'b0, max_val}) begin
        if (MODE == MODE_SAT) begin
          nxt     = max_val;
          wrap_up = (out != max_val);
        end else begin
          nxt     = up_wrap_s[WIDTH-1:0];
          wrap_up = 1'b1;
        end
      end else begin
        nxt = sum_s[WIDTH-1:0];
      end
    end else begin
      if (out > max_val) begin
        nxt = max_val;
      end else if (s > out) begin
        if (MODE == MODE_SAT) begin
          nxt     = {WIDTH{1'b0}};
          wrap_dn = (out != {WIDTH{1'b0}});
        end else begin
          nxt     = dn_wrap_s[WIDTH-1:0];
          wrap_dn = 1'b1;
        end
      end else begin
        nxt = out - s;
      end
    end
  end

endmodule

// File: rtl/updown_counter_param.sv
// Parametrised up/down counter with programmable modulus, runtime step, load,
// wrap/saturate mode and terminal-count / overflow / underflow / zero flags.
module updown_counter_param
  import updown_counter_pkg::*;
#(
  parameter int               WIDTH   = DEF_WIDTH,
  parameter count_mode_e      MODE    = MODE_WRAP,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_down,
  input  logic             ld,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] step,
  input  logic [WIDTH-1:0] max_val,
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             ovf,
  output logic             unf,
  output logic             zero
);

  logic [WIDTH-1:0] out_r;
  logic             ovf_r;
  logic             unf_r;
  logic [WIDTH-1:0] step_eff_s;
  logic [WIDTH-1:0] load_eff_s;
  logic [WIDTH-1:0] nxt_s;
  logic             wrap_up_s;
  logic             wrap_dn_s;

  assign step_eff_s = (step > max_val) ? max_val : step;
  assign load_eff_s = (load_val > max_val) ? max_val : load_val;

  updown_next_calc #(
    .WIDTH (WIDTH),
    .MODE  (MODE)
  ) u_next_calc (
    .out     (out_r),
    .s       (step_eff_s),
    .max_val (max_val),
    .up_down (up_down),
    .nxt     (nxt_s),
    .wrap_up (wrap_up_s),
    .wrap_dn (wrap_dn_s)
  );

  // Count and pulse registers: load beats enable, pulses last one cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_r <= RST_VAL;
      ovf_r <= 1'b0;
      unf_r <= 1'b0;
    end else if (ld) begin
      out_r <= load_eff_s;
      ovf_r <= 1'b0;
      unf_r <= 1'b0;
    end else if (en) begin
      out_r <= nxt_s;
      ovf_r <= wrap_up_s;
      unf_r <= wrap_dn_s;
    end else begin
      out_r <= out_r;
      ovf_r <= 1'b0;
      unf_r <= 1'b0;
    end
  end

  assign out  = out_r;
  assign ovf  = ovf_r;
  assign unf  = unf_r;
  assign zero = (out_r == {WIDTH{1'b0}});
  assign tc   = up_down ? (out_r == max_val) : (out_r == {WIDTH{1'b0}});

endmodule
